// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART.
//   OVERSAMPLE         ticks per bit period
//   PAR_NONE/ODD/EVEN  parity mode encodings for the PARITY parameter
//   tx_state_e         transmitter FSM states
//   rx_state_e         receiver FSM states
//   parity_bit()       parity bit to send/expect for a payload
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  // Payload is zero-extended to 9 bits; the extension does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PAR_EVEN) ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator.
//   clk      system clock
//   rst      synchronous active-high reset
//   restart  clears the divider so the next tick lands DIV clocks later
//   tick     one-clock pulse every DIV clocks
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart)  cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART, 16x oversampled RX.
//   clk, rst                  system clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready transmit byte stream (valid/ready)
//   tx                        serial out, idle high
//   rx                        serial in, asynchronous
//   rx_data/rx_valid/rx_ready receive byte stream (valid/ready)
//   rx_parity_err             parity mismatch on the held frame
//   rx_frame_err              first stop bit sampled low on the held frame
//   rx_overrun                1-cycle pulse when a frame is dropped because rx_valid was held
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX
  tx_state_e            tx_state;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic [3:0]           tx_tcnt;
  logic [3:0]           tx_bcnt;
  logic                 tx_tick;
  logic                 tx_accept;
  logic                 tx_bit_end;

  assign tx_accept  = (tx_state == TX_IDLE) && tx_valid && tx_ready;
  assign tx_bit_end = tx_tick && (tx_tcnt == LAST_TICK);

  // Restarting at accept makes the start bit (and every bit after it)
  // exactly OVERSAMPLE*DIV clocks long.
  uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(tx_accept),
    .tick   (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
    end else begin
      if (tx_tick) tx_tcnt <= tx_tcnt + 4'd1;
      case (tx_state)
        TX_IDLE: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_accept) begin
            tx_ready <= 1'b0;
            tx       <= 1'b0;
            tx_sh    <= tx_data;
            tx_par   <= parity_bit(9'(tx_data), PARITY);
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx       <= tx_sh[0];
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bcnt == LAST_BIT) begin
            tx_bcnt <= '0;
            if (PARITY != PAR_NONE) begin
              tx       <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            tx_bcnt <= tx_bcnt + 4'd1;
            tx      <= tx_sh[1];
            tx_sh   <= tx_sh >> 1;
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx       <= 1'b1;
          tx_state <= TX_STOP;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_bcnt == LAST_STOP) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end else begin
            tx_bcnt <= tx_bcnt + 4'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_e            rx_state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr;
  logic [3:0]           rx_tcnt;
  logic [3:0]           rx_bcnt;
  logic [1:0]           rx_vcnt;
  logic                 rx_tick;
  logic                 rx_restart;
  logic                 rx_sample;
  logic                 rx_bit_end;
  logic                 maj;

  assign rx_restart = (rx_state == RX_IDLE) && rx_prev && !rx_s2;
  assign rx_sample  = rx_tick && (rx_tcnt == 4'd9);
  assign rx_bit_end = rx_tick && (rx_tcnt == LAST_TICK);
  // Votes from ticks 7 and 8 plus the live tick-9 sample.
  assign maj = (rx_vcnt + {1'b0, rx_s2}) >= 2'd2;

  uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(rx_restart),
    .tick   (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_sh         <= '0;
      rx_perr       <= 1'b0;
      rx_tcnt       <= '0;
      rx_bcnt       <= '0;
      rx_vcnt       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_overrun <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
      end

      if (rx_tick) begin
        rx_tcnt <= rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd7)      rx_vcnt <= {1'b0, rx_s2};
        else if (rx_tcnt == 4'd8) rx_vcnt <= rx_vcnt + {1'b0, rx_s2};
      end

      case (rx_state)
        RX_IDLE: if (rx_restart) begin
          rx_tcnt  <= '0;
          rx_bcnt  <= '0;
          rx_perr  <= 1'b0;
          rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_sample && maj) rx_state <= RX_IDLE;  // false start
          else if (rx_bit_end)  rx_state <= RX_DATA;
        end
        RX_DATA: begin
          if (rx_sample) rx_sh <= {maj, rx_sh[DATA_BITS-1:1]};
          if (rx_bit_end) begin
            if (rx_bcnt == LAST_BIT) begin
              rx_bcnt <= '0;
              if (PARITY != PAR_NONE) rx_state <= RX_PARITY;
              else                    rx_state <= RX_STOP;
            end else begin
              rx_bcnt <= rx_bcnt + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_sample)  rx_perr  <= (maj != parity_bit(9'(rx_sh), PARITY));
          if (rx_bit_end) rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_sample) begin
          // A consumer handshake in this same cycle frees the slot.
          if (!rx_valid || rx_ready) begin
            rx_valid      <= 1'b1;
            rx_data       <= rx_sh;
            rx_parity_err <= (PARITY != PAR_NONE) && rx_perr;
            rx_frame_err  <= !maj;
          end else begin
            rx_overrun <= 1'b1;
          end
          // Low stop bit: hold off re-arming until the line idles high.
          if (maj) rx_state <= RX_IDLE;
          else     rx_state <= RX_BREAK;
        end
        RX_BREAK: if (rx_s2) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
